// File: rtl/mem_wr_pkg.sv
// mem_wr_pkg: shared types and constants for the memory write-stage arbiter.
//   state_t         : arbiter FSM states
//   OWN_*           : owner codes driven on the owner output
//   LAST_*          : encoding of the one-bit last_owner history
//   DATA_MSB_DEF    : default data MSB (data width is MSB+1)
//   BURST_W_DEF     : default DMA burst-length field width
package mem_wr_pkg;
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CPU_WR    = 2'd1,
        S_DMA_BURST = 2'd2,
        S_RELEASE   = 2'd3
    } state_t;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;
    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DMA = 1'b1;
    localparam int DATA_MSB_DEF = 63;
    localparam int BURST_W_DEF  = 4;
endpackage

// File: rtl/mem_wr_pick.sv
// mem_wr_pick: combinational requester pick, one-hot grant {dma, cpu}.
//   i_cpu_req    : CPU request level
//   i_dma_req    : DMA request level
//   i_last_owner : requester that owned the stage most recently
//   o_gnt        : one-hot grant, bit 0 CPU, bit 1 DMA
// Build option MEM_WR_ROUND_ROBIN_EN: ties go to the requester that is not
// last_owner; otherwise the CPU always wins ties.
module mem_wr_pick
    import mem_wr_pkg::*;
(
    input  logic       i_cpu_req,
    input  logic       i_dma_req,
    input  logic       i_last_owner,
    output logic [1:0] o_gnt
);
    logic w_cpu_win;
    always_comb begin
`ifdef MEM_WR_ROUND_ROBIN_EN
        w_cpu_win = i_cpu_req & (~i_dma_req | (i_last_owner == LAST_DMA));
`else
        w_cpu_win = i_cpu_req | (i_last_owner & 1'b0);
`endif
    end
    assign o_gnt = {i_dma_req & ~w_cpu_win, w_cpu_win};
endmodule

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: shares the memory write-register stage between a
// single-beat CPU store path and a burst DMA engine.
//   clk, reset_n            : clock, asynchronous active-low reset
//   cpu_req/cpu_data        : CPU request level and data (sampled at grant)
//   cpu_gnt/cpu_ack         : CPU owns the stage / one-cycle write pulse
//   dma_req/dma_len         : DMA burst request level, beats minus 1
//   dma_valid/dma_data      : DMA beat handshake and data
//   dma_gnt/dma_ack         : DMA owns the stage / beat accepted this cycle
//   wr_en/wr_data           : write-register drive, data zero when idle
//   busy/owner              : not IDLE / owner code (none, CPU, DMA)
// Build option MEM_WR_ROUND_ROBIN_EN selects round-robin tie-break in
// mem_wr_pick; default is fixed CPU priority.
module mem_write_arbiter
    import mem_wr_pkg::*;
#(
    parameter int N       = DATA_MSB_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic [N:0]         cpu_data,
    output logic               cpu_gnt,
    output logic               cpu_ack,
    input  logic               dma_req,
    input  logic [BURST_W-1:0] dma_len,
    input  logic               dma_valid,
    input  logic [N:0]         dma_data,
    output logic               dma_gnt,
    output logic               dma_ack,
    output logic               wr_en,
    output logic [N:0]         wr_data,
    output logic               busy,
    output logic [1:0]         owner
);
    state_t             r_state, w_state_nx;
    logic [BURST_W-1:0] r_beat_cnt, w_beat_cnt_nx;
    logic               r_last_owner, w_last_owner_nx;
    logic               r_cur_owner, w_cur_owner_nx;
    logic               r_wr_en, w_wr_en_nx;
    logic [N:0]         r_wr_data, w_wr_data_nx;
    logic               r_cpu_ack, w_cpu_ack_nx;
    logic [1:0]         w_pick;

    mem_wr_pick u_pick (
        .i_cpu_req    (cpu_req),
        .i_dma_req    (dma_req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_last_owner <= LAST_DMA;
            r_cur_owner  <= LAST_DMA;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_cpu_ack    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_beat_cnt   <= w_beat_cnt_nx;
            r_last_owner <= w_last_owner_nx;
            r_cur_owner  <= w_cur_owner_nx;
            r_wr_en      <= w_wr_en_nx;
            r_wr_data    <= w_wr_data_nx;
            r_cpu_ack    <= w_cpu_ack_nx;
        end
    end

    // Write outputs default to zero every cycle, so wr_data is cleared
    // whenever no beat is being registered.
    always_comb begin
        w_state_nx      = r_state;
        w_beat_cnt_nx   = r_beat_cnt;
        w_last_owner_nx = r_last_owner;
        w_cur_owner_nx  = r_cur_owner;
        w_wr_en_nx      = 1'b0;
        w_wr_data_nx    = '0;
        w_cpu_ack_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick[0]) begin
                    w_state_nx     = S_CPU_WR;
                    w_wr_en_nx     = 1'b1;
                    w_wr_data_nx   = cpu_data;
                    w_cpu_ack_nx   = 1'b1;
                    w_cur_owner_nx = LAST_CPU;
                end else if (w_pick[1]) begin
                    w_state_nx     = S_DMA_BURST;
                    w_beat_cnt_nx  = dma_len;
                    w_cur_owner_nx = LAST_DMA;
                end
            end
            S_CPU_WR: w_state_nx = S_RELEASE;
            S_DMA_BURST: begin
                if (!dma_req) begin
                    w_state_nx = S_RELEASE;
                end else if (dma_valid) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_data_nx = dma_data;
                    // Leave on the last beat instead of decrementing past zero.
                    if (r_beat_cnt == '0)
                        w_state_nx = S_RELEASE;
                    else
                        w_beat_cnt_nx = r_beat_cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nx      = S_IDLE;
                w_last_owner_nx = r_cur_owner;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign cpu_gnt = (r_state == S_CPU_WR);
    assign dma_gnt = (r_state == S_DMA_BURST);
    assign dma_ack = dma_gnt & dma_valid & dma_req;
    assign cpu_ack = r_cpu_ack;
    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != S_IDLE);
    assign owner   = cpu_gnt ? OWN_CPU : (dma_gnt ? OWN_DMA : OWN_NONE);
endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb_mem_write_arbiter: directed, table-driven bench for mem_write_arbiter.
module tb_mem_write_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_gnt, cpu_ack;
    logic [63:0] cpu_data;
    logic        dma_req, dma_valid, dma_gnt, dma_ack;
    logic [3:0]  dma_len;
    logic [63:0] dma_data;
    logic        wr_en, busy;
    logic [63:0] wr_data;
    logic [1:0]  owner;
    logic [71:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cr;
        logic [63:0] cd;
        logic        dr;
        logic [3:0]  dl;
        logic        dv;
        logic [63:0] dd;
        logic        ew;
        logic [63:0] ed;
        logic        eca;
        logic        eda;
        logic        eb;
        logic [1:0]  eo;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    mem_write_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_data  (cpu_data),
        .cpu_gnt   (cpu_gnt),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_len   (dma_len),
        .dma_valid (dma_valid),
        .dma_data  (dma_data),
        .dma_gnt   (dma_gnt),
        .dma_ack   (dma_ack),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .owner     (owner)
    );

    assign outs = {wr_en, wr_data, cpu_ack, dma_ack, cpu_gnt, dma_gnt, busy, owner};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic cr, input logic [63:0] cd, input logic dr,
                               input logic [3:0] dl, input logic dv, input logic [63:0] dd,
                               input logic ew, input logic [63:0] ed, input logic eca,
                               input logic eda, input logic eb, input logic [1:0] eo);
        vec_t r;
        r.cr = cr; r.cd = cd; r.dr = dr; r.dl = dl; r.dv = dv; r.dd = dd;
        r.ew = ew; r.ed = ed; r.eca = eca; r.eda = eda; r.eb = eb; r.eo = eo;
        return r;
    endfunction

    task automatic idle_row();
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, wr_cnt, cyc, idle_at, cnt, n;
        logic seen;
        logic [1:0] prev_owner;
        logic [1:0] got [3];
        logic [1:0] exp_t [3];
        reset_n = 1'b0;
        cpu_req = 0; cpu_data = 0; dma_req = 0; dma_len = 0; dma_valid = 0; dma_data = 0;
        repeat (2) @(posedge clk);
        #1 chk("reset_held", outs, 72'd0);
        reset_n = 1'b1;

        repeat (3) idle_row();
        // CPU single write
        tv.push_back(v(1, 64'hDEADBEEF01234567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(1, 64'h0, 0, 0, 0, 0, 1, 64'hDEADBEEF01234567, 1, 0, 1, 2'b01));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00));
        idle_row();
        // DMA burst of 4, continuous valid; dma_len changed after grant
        tv.push_back(v(0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 2, 1, 1, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 3, 1, 2, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 4, 1, 3, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 2'b00));
        idle_row();
        // DMA burst of 4 with a stall in cycle 2
        tv.push_back(v(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 0, 64'h55, 1, 1, 0, 0, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 2, 0, 0, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 3, 1, 2, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 1, 0, 1, 4, 1, 3, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 2'b00));
        idle_row();
        // Single-beat burst
        tv.push_back(v(0, 0, 1, 0, 1, 64'hA, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 1, 64'hA, 0, 0, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hA, 0, 0, 1, 2'b00));
        idle_row();
        // Abort: dma_req dropped mid-burst
        tv.push_back(v(0, 0, 1, 5, 1, 9, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 5, 1, 9, 0, 0, 0, 1, 1, 2'b10));
        tv.push_back(v(0, 0, 0, 5, 1, 7, 1, 9, 0, 0, 1, 2'b10));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00));
        idle_row();

        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            cpu_req = tv[i].cr; cpu_data = tv[i].cd; dma_req = tv[i].dr;
            dma_len = tv[i].dl; dma_valid = tv[i].dv; dma_data = tv[i].dd;
            @(negedge clk);
            chk($sformatf("row%0d", i), outs,
                {tv[i].ew, tv[i].ed, tv[i].eca, tv[i].eda, tv[i].eo == 2'b01,
                 tv[i].eo == 2'b10, tv[i].eb, tv[i].eo});
        end

        // Maximum-length burst: 16 beats, no counter wrap
        @(posedge clk);
        #1 dma_req = 1; dma_len = 4'hF; dma_valid = 1; dma_data = 64'd1;
        acc = 0; wr_cnt = 0; cyc = 0; idle_at = -1;
        while (cyc < 40 && idle_at < 0) begin
            @(negedge clk);
            if (wr_en) begin
                wr_cnt++;
                chk("burst16_data", 72'(wr_data), 72'(wr_cnt));
            end
            if (dma_ack) acc++;
            if (cyc > 0 && !busy) idle_at = cyc;
            @(posedge clk);
            #1 cyc++;
            dma_data = 64'(acc + 1);
            if (acc == 16) dma_req = 0;
        end
        dma_req = 0; dma_valid = 0; dma_data = 0; dma_len = 0;
        chk("burst16_writes", 72'(wr_cnt), 72'd16);
        chk("burst16_accepts", 72'(acc), 72'd16);
        chk("burst16_idle_cycle", 72'(idle_at), 72'd18);

        // Asynchronous reset after beat 2 of 4
        @(posedge clk);
        #1 dma_req = 1; dma_len = 4'd3; dma_valid = 1; dma_data = 64'd1;
        acc = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (dma_ack) acc++;
            if (wr_en && wr_data == 64'd2) seen = 1;
            else begin
                @(posedge clk);
                #1 dma_data = 64'(acc + 1);
            end
        end
        chk("midburst_beat2_seen", 72'(seen), 72'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outs", outs, 72'd0);
        dma_req = 0; dma_valid = 0; dma_data = 0; dma_len = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en || busy) cnt++;
        end
        chk("no_activity_after_reset", 72'(cnt), 72'd0);

        // Both requests held from reset release
`ifdef MEM_WR_ROUND_ROBIN_EN
        exp_t = '{2'b01, 2'b10, 2'b01};
`else
        exp_t = '{2'b01, 2'b01, 2'b01};
`endif
        got = '{2'b00, 2'b00, 2'b00};
        reset_n = 1'b0;
        cpu_req = 1; cpu_data = 64'h11; dma_req = 1; dma_len = 0; dma_valid = 1; dma_data = 64'h22;
        @(posedge clk);
        #1 reset_n = 1'b1;
        prev_owner = 2'b00; n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (owner != 2'b00 && prev_owner == 2'b00) begin
                got[n] = owner;
                n++;
            end
            prev_owner = owner;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("tie_grant%0d", i), 72'(got[i]), 72'(exp_t[i]));

        cpu_req = 0; dma_req = 0; dma_valid = 0;
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Controller that sequences and shares the 64-bit memory write-register stage between the CPU store path and the DMA engine. It arbitrates between a single-beat CPU requester and a burst DMA requester, then drives the write-enable and write-data inputs of the write register. Its outputs follow the register's clear-when-idle convention: `wr_data` is zero whenever `wr_en` is low. It sits between the CPU/DMA request logic and the memory write stage.

## Interface
- `N`, 63, data MSB; data width is N+1.
- `BURST_W`, 4, width of the DMA burst-length field; max burst is 2^BURST_W beats.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU write request; level, held until `cpu_ack`.
- `cpu_data` in N+1: CPU write data, sampled at the grant edge.
- `cpu_gnt` out 1: CPU owns the write stage.
- `cpu_ack` out 1: one-cycle pulse, coincident with the CPU write.
- `dma_req` in 1: DMA burst request; level, held for the whole burst.
- `dma_len` in BURST_W: beats minus 1, sampled at the grant edge.
- `dma_valid` in 1: DMA beat valid.
- `dma_data` in N+1: DMA beat data.
- `dma_gnt` out 1: DMA owns the write stage.
- `dma_ack` out 1: combinational; `dma_gnt & dma_valid & dma_req` in DMA_BURST means the beat is accepted this cycle.
- `wr_en` out 1: drives the write register's enable.
- `wr_data` out N+1: drives the write register's data; zero when `wr_en`=0.
- `busy` out 1: state is not IDLE.
- `owner` out 2: owner code, 00 none, 01 CPU, 10 DMA.

## Operation
- FSM states: IDLE, CPU_WR, DMA_BURST, RELEASE. `beat_cnt` is BURST_W bits wide. `last_owner` is 1 bit.
- **IDLE**
  - No request: stay in IDLE.
  - Only one request: grant that requester.
  - Both requests: tie resolved per Configuration.
  - CPU grant: go to CPU_WR; `wr_data`<=`cpu_data`, `wr_en`<=1, `cpu_ack`<=1.
  - DMA grant: go to DMA_BURST; `beat_cnt`<=`dma_len`.
- **CPU_WR**: lasts exactly one cycle, then RELEASE. Clear `wr_en`, `wr_data` and `cpu_ack`.
- **DMA_BURST** (all per cycle)
  - Accepted beat: `wr_en`<=1, `wr_data`<=`dma_data`.
  - If `beat_cnt`==0, go to RELEASE; otherwise decrement `beat_cnt`.
  - `dma_valid`=0: stall; `wr_en`<=0, `wr_data`<=0.
  - `dma_req`=0: abort; no beat accepted, go to RELEASE.
- **RELEASE**: one turnaround cycle.
  - Grants are low; `last_owner` updated.
  - `wr_en` reflects the final registered beat from the previous cycle, then goes to 0.
  - Next state is IDLE.
- `cpu_gnt`/`dma_gnt` are high only in CPU_WR/DMA_BURST respectively. `owner` tracks the grants.
- A request still high in IDLE after its ack is treated as a new request.
- Reset (asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - `beat_cnt`=0; `last_owner`=DMA.
  - Applies mid-burst as well. Remaining beats are dropped and no write is emitted after reset release without a new request.

## Timing
- `wr_en`/`wr_data`/`cpu_ack` are registered; the grants are registered from the state.
- CPU: `cpu_req` high in IDLE at cycle 0.
  - Cycle 1: `cpu_gnt`, `cpu_ack`, `wr_en` high; `wr_data` = `cpu_data` from cycle 0.
  - Cycle 2: RELEASE.
  - Cycle 3: IDLE.
  - Throughput is one write per 3 cycles.
- DMA: `dma_req` high in IDLE at cycle 0.
  - Cycle 1: `dma_gnt` high.
  - A beat accepted in cycle j appears on `wr_en`/`wr_data` in cycle j+1.
  - With continuous valid and length L+1, beats are accepted in cycles 1..L+1, `wr_en` is high in cycles 2..L+2, RELEASE is cycle L+2, and IDLE is cycle L+3.
- `dma_len`=0 gives a single-beat burst. `dma_len`=all-ones gives 2^BURST_W beats; `beat_cnt` does not wrap.

## Configuration
- `MEM_WR_ROUND_ROBIN_EN` defined: ties go to the requester that is not `last_owner`.
- Undefined: fixed priority, CPU always wins ties. DMA can starve under continuous CPU traffic; this is accepted.

## Structure
- Package `mem_wr_pkg` holds:
  - the state enum;
  - owner codes `OWN_NONE`/`OWN_CPU`/`OWN_DMA`;
  - default data and burst widths.
- One sub-module, `mem_wr_pick`: a combinational tie-break from `cpu_req`, `dma_req`, `last_owner` to a one-hot grant. The macro affects only this sub-module.

## Test plan
- Reset held, then released with no requests -> all outputs 0, `busy`=0 indefinitely.
- `cpu_req` with `cpu_data`=0xDEADBEEF01234567 -> cycle 1 `wr_en`=1 with that data and `cpu_ack`=1; cycle 2 `wr_data`=0; `busy` low at cycle 3.
- `dma_len`=3, data 1,2,3,4 with continuous valid -> `wr_en` in cycles 2–5 carrying 1..4; four `dma_ack` pulses; IDLE at cycle 6.
- Same burst with `dma_valid` low in cycle 2 -> one-cycle `wr_en` gap with `wr_data`=0; still exactly 4 writes, 1..4 in order.
- Both requests held from reset release:
  - Round-robin: order is CPU, DMA, CPU.
  - Without macro: CPU, CPU, CPU.
- `reset_n` pulled low after DMA beat 2 of 4 -> outputs 0 asynchronously, state IDLE; no further `wr_en` until a new request.
